// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix write scheduler: field widths,
// data-word layout and the scheduler FSM states.
package led_matrix_pkg;

  localparam int ADR_W         = 9;
  localparam int COL_W         = 12;
  localparam int DATA_W        = 32;
  localparam int ADR_LSB       = 16;
  localparam int COL_LSB       = 0;
  localparam int FILL_LAST_DEF = 511;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/led_wr_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant from the eligible
// requests, with a registered pointer remembering which port won last.
module led_wr_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_last
);

  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // On a tie the port that did not win last time takes the slot.
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Pointer starts at 1 so port 0 takes the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (|i_req) begin
      r_last <= o_gnt[1];
    end
  end

  assign o_last = r_last;

endmodule

// File: rtl/led_matrix_wr_sched.sv
// Write scheduler for the LED matrix: arbitrates two pixel-write requesters
// and runs full-frame fills, emitting one registered write word per cycle.
module led_matrix_wr_sched
  import led_matrix_pkg::*;
#(
  parameter int P_ADR_W     = ADR_W,
  parameter int P_COL_W     = COL_W,
  parameter int P_FILL_LAST = FILL_LAST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [P_ADR_W-1:0] adr0,
  input  logic [P_COL_W-1:0] dat0,
  output logic               ack0,
  input  logic               req1,
  input  logic [P_ADR_W-1:0] adr1,
  input  logic [P_COL_W-1:0] dat1,
  output logic               ack1,
  input  logic               fill_start,
  input  logic [P_COL_W-1:0] fill_color,
  output logic               fill_busy,
  output logic               fill_done,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_out_en
);

  localparam logic [P_ADR_W-1:0] L_FILL_LAST = P_ADR_W'(P_FILL_LAST);

  state_t              r_state;
  logic [P_ADR_W-1:0]  r_cnt;
  logic                r_fill_end;
  logic [P_COL_W-1:0]  r_fill_color;
  logic [DATA_W-1:0]   r_data;
  logic                r_en;
  logic [1:0]          r_ack;
  logic                r_busy;
  logic                r_done;

  logic [1:0]          w_req;
  logic [1:0]          w_arb_req;
  logic [1:0]          w_gnt;
  logic                w_rr_last;
  logic                w_idle_free;
  logic                w_sel1;
  logic [P_ADR_W-1:0]  w_sel_adr;
  logic [P_COL_W-1:0]  w_sel_col;
  logic [DATA_W-1:0]   w_req_word;
  logic [DATA_W-1:0]   w_fill_word;

  assign w_req       = {req1, req0};
  // A pending fill_start claims the cycle, so requesters only compete otherwise.
  assign w_idle_free = (r_state == ST_IDLE) && !fill_start;

  // A port whose ack is on the outputs this cycle is still holding its request;
  // masking it keeps the same request from being issued twice.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign w_arb_req[gi] = w_req[gi] & ~r_ack[gi] & w_idle_free;
    end
  endgenerate

  led_wr_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_req  (w_arb_req),
    .o_gnt  (w_gnt),
    .o_last (w_rr_last)
  );

  // Port 1 is selected when it is alone, or when it ties and port 0 won last.
  assign w_sel1    = w_arb_req[1] & (~w_arb_req[0] | ~w_rr_last);
  assign w_sel_adr = w_sel1 ? adr1 : adr0;
  assign w_sel_col = w_sel1 ? dat1 : dat0;

  always_comb begin
    w_req_word                         = '0;
    w_req_word[ADR_LSB +: P_ADR_W]     = w_sel_adr;
    w_req_word[COL_LSB +: P_COL_W]     = w_sel_col;
    w_fill_word                        = '0;
    w_fill_word[ADR_LSB +: P_ADR_W]    = r_cnt;
    w_fill_word[COL_LSB +: P_COL_W]    = r_fill_color;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_fill_end   <= 1'b0;
      r_fill_color <= '0;
      r_data       <= '0;
      r_en         <= 1'b0;
      r_ack        <= 2'b00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_en   <= 1'b0;
      r_ack  <= 2'b00;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fill_start) begin
            r_state      <= ST_FILL;
            r_fill_color <= fill_color;
            r_cnt        <= '0;
            r_fill_end   <= 1'b0;
            r_busy       <= 1'b1;
          end else if (|w_gnt) begin
            r_en   <= 1'b1;
            r_ack  <= w_gnt;
            r_data <= w_req_word;
          end
        end
        ST_FILL: begin
          // The cycle after the last write has been issued moves to DONE,
          // so fill_done trails the final address on the bus by one cycle.
          if (r_fill_end) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_en   <= 1'b1;
            r_data <= w_fill_word;
            if (r_cnt == L_FILL_LAST) begin
              r_fill_end <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = r_data;
  assign data_out_en = r_en;
  assign ack0        = r_ack[0];
  assign ack1        = r_ack[1];
  assign fill_busy   = r_busy;
  assign fill_done   = r_done;

endmodule

// File: tb/tb_led_matrix_wr_sched.sv
// Directed bench for led_matrix_wr_sched: requester writes, round-robin,
// full fills with interference, fill abort by reset, fill-vs-request priority.
module tb_led_matrix_wr_sched;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [8:0]  adr0;
  logic [11:0] dat0;
  logic        ack0;
  logic        req1;
  logic [8:0]  adr1;
  logic [11:0] dat1;
  logic        ack1;
  logic        fill_start;
  logic [11:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic [31:0] data_out;
  logic        data_out_en;

  int n_checks = 0;
  int n_fail   = 0;

  led_matrix_wr_sched dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .adr0        (adr0),
    .dat0        (dat0),
    .ack0        (ack0),
    .req1        (req1),
    .adr1        (adr1),
    .dat1        (dat1),
    .ack1        (ack1),
    .fill_start  (fill_start),
    .fill_color  (fill_color),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .data_out    (data_out),
    .data_out_en (data_out_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " data_out"}, data_out, 32'h0);
    chk({tag, " en"},       {31'b0, data_out_en}, 32'h0);
    chk({tag, " ack0"},     {31'b0, ack0}, 32'h0);
    chk({tag, " ack1"},     {31'b0, ack1}, 32'h0);
    chk({tag, " busy"},     {31'b0, fill_busy}, 32'h0);
    chk({tag, " done"},     {31'b0, fill_done}, 32'h0);
  endtask

  function automatic logic [31:0] fill_word(input int a, input logic [11:0] c);
    logic [31:0] w;
    w = 32'h0;
    w[24:16] = a[8:0];
    w[11:0]  = c;
    return w;
  endfunction

  initial begin
    reset = 1'b1; req0 = 1'b0; adr0 = '0; dat0 = '0;
    req1 = 1'b0; adr1 = '0; dat1 = '0; fill_start = 1'b0; fill_color = '0;

    // Reset state
    tick(); tick();
    chk_idle_outputs("reset");
    reset = 1'b0;

    // Single request on port 0
    req0 = 1'b1; adr0 = 9'h005; dat0 = 12'hF0A;
    tick();
    chk("single data_out", data_out, 32'h0005_0F0A);
    chk("single en",   {31'b0, data_out_en}, 32'h1);
    chk("single ack0", {31'b0, ack0}, 32'h1);
    chk("single ack1", {31'b0, ack1}, 32'h0);
    $display("write port0 adr=%h dat=%h word=%h", adr0, dat0, data_out);
    req0 = 1'b0;
    tick();
    chk("single one write", {31'b0, data_out_en}, 32'h0);

    // Both ports held high from reset: strict alternation starting with port 0
    reset = 1'b1; tick(); reset = 1'b0;
    req0 = 1'b1; adr0 = 9'h011; dat0 = 12'h111;
    req1 = 1'b1; adr1 = 9'h1FF; dat1 = 12'hABC;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr en",   {31'b0, data_out_en}, 32'h1);
      chk("rr ack0", {31'b0, ack0}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr ack1", {31'b0, ack1}, (i % 2 == 1) ? 32'h1 : 32'h0);
      chk("rr data", data_out, (i % 2 == 0) ? 32'h0011_0111 : 32'h01FF_0ABC);
      $display("rr write %0d ack0=%0b ack1=%0b word=%h", i, ack0, ack1, data_out);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("rr stop en", {31'b0, data_out_en}, 32'h0);

    // Plain full fill
    fill_start = 1'b1; fill_color = 12'h00F;
    tick();
    fill_start = 1'b0;
    chk("fillA busy", {31'b0, fill_busy}, 32'h1);
    chk("fillA en0",  {31'b0, data_out_en}, 32'h0);
    for (int a = 0; a < 512; a++) begin
      tick();
      chk("fillA en",   {31'b0, data_out_en}, 32'h1);
      chk("fillA word", data_out, fill_word(a, 12'h00F));
      chk("fillA done early", {31'b0, fill_done}, 32'h0);
    end
    tick();
    chk("fillA done", {31'b0, fill_done}, 32'h1);
    chk("fillA en after last", {31'b0, data_out_en}, 32'h0);
    chk("fillA busy in done", {31'b0, fill_busy}, 32'h1);
    tick();
    chk("fillA done pulse", {31'b0, fill_done}, 32'h0);
    chk("fillA busy low",   {31'b0, fill_busy}, 32'h0);
    chk("fillA en idle",    {31'b0, data_out_en}, 32'h0);
    $display("fill color=00F complete");

    // Fill with req1 pending and a fill_start re-pulse mid-fill
    fill_start = 1'b1; fill_color = 12'h7E1;
    tick();
    fill_start = 1'b0;
    for (int a = 0; a < 512; a++) begin
      if (a == 10) begin
        req1 = 1'b1; adr1 = 9'h0AB; dat1 = 12'h123;
      end
      fill_start = (a == 200);
      tick();
      chk("fillB en",   {31'b0, data_out_en}, 32'h1);
      chk("fillB word", data_out, fill_word(a, 12'h7E1));
      chk("fillB ack1", {31'b0, ack1}, 32'h0);
    end
    fill_start = 1'b0;
    tick();
    chk("fillB done", {31'b0, fill_done}, 32'h1);
    chk("fillB en stop", {31'b0, data_out_en}, 32'h0);
    chk("fillB ack1 in done", {31'b0, ack1}, 32'h0);
    tick();
    chk("fillB busy low", {31'b0, fill_busy}, 32'h0);
    chk("fillB en idle",  {31'b0, data_out_en}, 32'h0);
    tick();
    chk("fillB ack1", {31'b0, ack1}, 32'h1);
    chk("fillB req1 word", data_out, 32'h00AB_0123);
    $display("write port1 after fill word=%h", data_out);
    req1 = 1'b0;
    tick();
    chk("fillB no restart", {31'b0, fill_busy}, 32'h0);
    chk("fillB quiet", {31'b0, data_out_en}, 32'h0);

    // fill_start and req0 in the same cycle: fill wins
    fill_start = 1'b1; fill_color = 12'h0F0;
    req0 = 1'b1; adr0 = 9'h155; dat0 = 12'h5A5;
    tick();
    fill_start = 1'b0;
    chk("prio ack0", {31'b0, ack0}, 32'h0);
    chk("prio en",   {31'b0, data_out_en}, 32'h0);
    chk("prio busy", {31'b0, fill_busy}, 32'h1);
    for (int a = 0; a < 512; a++) begin
      tick();
      chk("prio fill word", data_out, fill_word(a, 12'h0F0));
      chk("prio fill ack0", {31'b0, ack0}, 32'h0);
    end
    tick();
    chk("prio done", {31'b0, fill_done}, 32'h1);
    chk("prio ack0 in done", {31'b0, ack0}, 32'h0);
    tick();
    chk("prio ack0 idle", {31'b0, ack0}, 32'h0);
    tick();
    chk("prio ack0", {31'b0, ack0}, 32'h1);
    chk("prio req0 word", data_out, 32'h0155_05A5);
    $display("write port0 after fill word=%h", data_out);
    req0 = 1'b0;
    tick();

    // Reset while the fill is at address 100
    fill_start = 1'b1; fill_color = 12'h321;
    tick();
    fill_start = 1'b0;
    for (int a = 0; a <= 100; a++) begin
      tick();
      chk("abort fill word", data_out, fill_word(a, 12'h321));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle_outputs("abort");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort no write", {31'b0, data_out_en}, 32'h0);
      chk("abort no done",  {31'b0, fill_done}, 32'h0);
      chk("abort no busy",  {31'b0, fill_busy}, 32'h0);
    end
    $display("fill aborted at address 100");
    // Back in IDLE with the pointer reset: a tie goes to port 0
    req0 = 1'b1; adr0 = 9'h0C3; dat0 = 12'h456;
    req1 = 1'b1; adr1 = 9'h03C; dat1 = 12'h789;
    tick();
    chk("abort idle ack0", {31'b0, ack0}, 32'h1);
    chk("abort idle word", data_out, 32'h00C3_0456);
    $display("write port0 after abort word=%h", data_out);
    req0 = 1'b0;
    tick();
    chk("abort idle ack1", {31'b0, ack1}, 32'h1);
    chk("abort idle word1", data_out, 32'h003C_0789);
    $display("write port1 after abort word=%h", data_out);
    req1 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
